// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one single-ported data memory between the instruction-fetch
//            and load/store ports. Sub-word stores become read-modify-write
//            sequences when MEM_ARB_RMW_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RADDR    = 3'd1,
    RDATA    = 3'd2,
    WRITE    = 3'd3,
    MR_RADDR = 3'd4,
    MR_RDATA = 3'd5,
    MR_WRITE = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

  state_t      r_state;
  state_t      w_nextState;
  logic        r_portI;
  logic [3:0]  r_starveCnt;
  logic        w_grantI;
  logic        w_grantD;

`ifdef MEM_ARB_RMW_EN
  localparam logic [3:0] c_BE_FULL = 4'b1111;
  localparam logic [3:0] c_BE_NONE = 4'b0000;

  logic [3:0]  r_be;
  logic [31:0] w_merged;

  // mem_wdata still holds the latched store data while the old word arrives
  always_comb begin
    w_merged = mem_wdata;
    for (int k = 0; k < 4; k++) begin
      if (!r_be[k]) begin
        w_merged[8*k +: 8] = mem_rdata[8*k +: 8];
      end
    end
  end
`else
  logic w_unusedBe;
  assign w_unusedBe = ^d_be;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_grantI    = 1'b0;
    w_grantD    = 1'b0;
    w_nextState = r_state;
    mem_wr      = 1'b0;
    i_ack       = 1'b0;
    d_ack       = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (i_req && (!d_req || r_starveCnt == c_STARVE_MAX)) begin
          w_grantI = 1'b1;
        end else if (d_req) begin
          w_grantD = 1'b1;
        end
        if (w_grantI || (w_grantD && !d_we)) begin
          w_nextState = RADDR;
        end else if (w_grantD) begin
`ifdef MEM_ARB_RMW_EN
          w_nextState = (d_be == c_BE_FULL || d_be == c_BE_NONE) ? WRITE : MR_RADDR;
`else
          w_nextState = WRITE;
`endif
        end
      end
      RADDR: w_nextState = RDATA;
      RDATA: w_nextState = DONE;
      WRITE: begin
`ifdef MEM_ARB_RMW_EN
        mem_wr = (r_be != c_BE_NONE);
`else
        mem_wr = 1'b1;
`endif
        w_nextState = DONE;
      end
`ifdef MEM_ARB_RMW_EN
      MR_RADDR: w_nextState = MR_RDATA;
      MR_RDATA: w_nextState = MR_WRITE;
      MR_WRITE: begin
        mem_wr      = 1'b1;
        w_nextState = DONE;
      end
`endif
      DONE: begin
        i_ack       = r_portI;
        d_ack       = !r_portI;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_portI     <= 1'b0;
      r_starveCnt <= 4'd0;
      mem_raddr   <= 32'd0;
      mem_waddr   <= 32'd0;
      mem_wdata   <= 32'd0;
      i_rdata     <= 32'd0;
      d_rdata     <= 32'd0;
`ifdef MEM_ARB_RMW_EN
      r_be        <= 4'd0;
`endif
    end else begin
      if (w_grantI || w_grantD) begin
        r_portI   <= w_grantI;
        mem_raddr <= w_grantI ? i_addr : d_addr;
        mem_waddr <= w_grantI ? i_addr : d_addr;
      end
      if (w_grantD && d_we) begin
        mem_wdata <= d_wdata;
`ifdef MEM_ARB_RMW_EN
        r_be      <= d_be;
`endif
      end
      // Starvation is only counted while the fetch port is actually waiting
      if (w_grantI) begin
        r_starveCnt <= 4'd0;
      end else if (w_grantD && i_req && r_starveCnt < c_STARVE_MAX) begin
        r_starveCnt <= r_starveCnt + 4'd1;
      end
      if (r_state == RDATA) begin
        if (r_portI) begin
          i_rdata <= mem_rdata;
        end else begin
          d_rdata <= mem_rdata;
        end
      end
`ifdef MEM_ARB_RMW_EN
      if (r_state == MR_RDATA) begin
        mem_wdata <= w_merged;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Randomized and directed bench for mem_arbiter with a word-level
//            memory and a reference model of contents, latency and grant order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int STARVE = 2;
`ifdef MEM_ARB_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic [31:0] mem_rdata;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Synchronous-read memory; the bench preloads words through the poke port
  logic [31:0] mem [0:16383];
  logic        pokeEn = 1'b0;
  logic [13:0] pokeIdx = 14'd0;
  logic [31:0] pokeData = 32'd0;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_raddr[15:2]];
    if (mem_wr) mem[mem_waddr[15:2]] <= mem_wdata;
    else if (pokeEn) mem[pokeIdx] <= pokeData;
  end

  logic [31:0] refMem [0:16383];

  function automatic logic [31:0] storeModel(input logic [31:0] old, input logic [3:0] be,
                                             input logic [31:0] data);
    logic [31:0] r;
    if (!RMW) return data;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = be[k] ? data[8*k +: 8] : old[8*k +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    pokeEn   = 1'b1;
    pokeIdx  = 14'(idx);
    pokeData = data;
    @(posedge clk);
    @(negedge clk);
    pokeEn = 1'b0;
    refMem[idx] = data;
  endtask

  task automatic checkOutputsZero(input string tag);
    check($sformatf("%s.ctl", tag), {28'd0, i_ack, d_ack, mem_wr, busy}, 32'd0);
    check($sformatf("%s.raddr", tag), mem_raddr, 32'd0);
    check($sformatf("%s.waddr", tag), mem_waddr, 32'd0);
    check($sformatf("%s.wdata", tag), mem_wdata, 32'd0);
    check($sformatf("%s.irdata", tag), i_rdata, 32'd0);
    check($sformatf("%s.drdata", tag), d_rdata, 32'd0);
  endtask

  // One transaction on an otherwise idle arbiter, starting just after a negedge
  task automatic runTxn(input string tag, input bit isI, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int lat, nWr, expLat, expWr;
    bit got;
    int idx;
    logic [31:0] expWord;
    idx = int'(addr[15:2]);
    expWord = refMem[idx];
    if (isI) begin
      i_req = 1'b1; i_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    end
    lat = 0; nWr = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (mem_wr) nWr++;
      got = isI ? i_ack : d_ack;
    end
    check($sformatf("%s.otherAck", tag), {31'd0, isI ? d_ack : i_ack}, 32'd0);
    i_req = 1'b0;
    d_req = 1'b0;
    if (isI || !we) begin
      expLat = 3; expWr = 0;
    end else begin
      expLat = (RMW && be != 4'hF && be != 4'h0) ? 4 : 2;
      expWr  = (RMW && be == 4'h0) ? 0 : 1;
      refMem[idx] = storeModel(refMem[idx], be, wdata);
    end
    check($sformatf("%s.latency", tag), 32'(lat), 32'(expLat));
    check($sformatf("%s.writes", tag), 32'(nWr), 32'(expWr));
    check($sformatf("%s.raddr", tag), mem_raddr, addr);
    if (isI) check($sformatf("%s.irdata", tag), i_rdata, expWord);
    else if (!we) check($sformatf("%s.drdata", tag), d_rdata, expWord);
    else check($sformatf("%s.mem", tag), mem[idx], refMem[idx]);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s.idleBusy", tag), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int starve;
    reset = 1'b1;
    i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;
    repeat (2) @(negedge clk);
    checkOutputsZero("reset");
    reset = 1'b0;

    for (int w = 0; w < 128; w++) poke(w, $urandom);

    // Directed scenarios
    poke(32'h100 >> 2, 32'hDEADBEEF);
    runTxn("fetch", 1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'd0);
    check("fetch.const", i_rdata, 32'hDEADBEEF);
    runTxn("store20", 1'b0, 1'b1, 4'hF, 32'h0000_0020, 32'h12345678);
    runTxn("load20", 1'b0, 1'b0, 4'hF, 32'h0000_0020, 32'd0);
    check("load20.const", d_rdata, 32'h12345678);
    poke(32'h40 >> 2, 32'hAABBCCDD);
    runTxn("rmw40", 1'b0, 1'b1, 4'b0010, 32'h0000_0040, 32'h00001100);
    check("rmw40.const", mem[16], RMW ? 32'hAABB11DD : 32'h00001100);
    runTxn("beZero", 1'b0, 1'b1, 4'b0000, 32'h0000_0060, 32'hCAFEF00D);

    // Reset in the middle of a partial store
    poke(32, 32'h55667788);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = 32'h80; d_wdata = 32'h0000EE00;
    repeat (RMW ? 2 : 1) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    d_req = 1'b0;
    #1;
    check("midReset.wr", {31'd0, mem_wr}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutputsZero("midReset");
    check("midReset.mem", mem[32], refMem[32]);
    reset = 1'b0;
    runTxn("postReset", 1'b1, 1'b0, 4'h0, 32'h0000_0080, 32'd0);

    // Both ports held busy: grant order follows the starvation rule
    i_addr = 32'($urandom_range(0, 127)) << 2;
    d_addr = 32'($urandom_range(0, 127)) << 2;
    d_we = 1'b0; d_be = 4'hF;
    i_req = 1'b1; d_req = 1'b1;
    starve = 0;
    for (int n = 0; n < 6; n++) begin
      logic [1:0] expPort;
      logic [1:0] obs;
      int gap;
      if (starve == STARVE) begin
        expPort = 2'b10; starve = 0;
      end else begin
        expPort = 2'b01;
        if (starve < STARVE) starve++;
      end
      gap = 0; obs = 2'b00;
      while (obs == 2'b00 && gap < 10) begin
        @(posedge clk);
        gap++;
        @(negedge clk);
        obs = {i_ack, d_ack};
      end
      check($sformatf("contend%0d.port", n), {30'd0, obs}, {30'd0, expPort});
      check($sformatf("contend%0d.gap", n), 32'(gap), (n == 0) ? 32'd3 : 32'd4);
      if (obs == 2'b10) begin
        check($sformatf("contend%0d.irdata", n), i_rdata, refMem[i_addr[15:2]]);
        i_addr = 32'($urandom_range(0, 127)) << 2;
      end else begin
        check($sformatf("contend%0d.drdata", n), d_rdata, refMem[d_addr[15:2]]);
        d_addr = 32'($urandom_range(0, 127)) << 2;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Randomized single transactions against the reference memory
    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a = {16'($urandom), 16'(32'($urandom_range(0, 127)) << 2)};
      runTxn($sformatf("rand%0d", n), kind == 0, kind == 2, 4'($urandom_range(0, 15)),
             a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
